// File: rtl/a_buffer_loader.sv
// -----------------------------------------------------------------------------
// a_buffer_loader
//
// Write-side producer for the activation (A) buffer. Copies a row-major
// activation tile from the PS-filled source BRAM into the ARRAY_N per-row RAMs
// of the A buffer, one element per cycle, and pulses done once the whole tile
// is resident.
//
// Element (r,k), r < num_rows, k < row_len, is read from
// src_base_addr + r*row_len + k (wrapping modulo 2^SRC_ADDR_WIDTH) and written
// to row RAM r at dst_base_addr + k with a one-hot write enable 1<<r.
//
// Ports
//   clk                 rising-edge clock
//   reset               synchronous, active-low reset
//   start               launch request, sampled only while idle
//   src_base_addr       source address of element (0,0)
//   dst_base_addr       A-buffer address of column 0 for every row
//   num_rows            rows to load, legal 1..ARRAY_N
//   row_len             elements per row, legal 1..RAM_SIZE
//   src_rd_en           source BRAM read enable
//   src_rd_addr         source BRAM read address
//   src_rd_data         source read data, valid one cycle after src_rd_en
//   bram_to_ram_w_addr  A-buffer write address
//   bram_to_ram_w_en    one-hot row-RAM write enable
//   bram_to_ram_w_data  A-buffer write data
//   busy                transfer in progress
//   done                one-cycle pulse, transfer complete
//   err                 one-cycle pulse, start rejected (illegal parameters)
//   dbg_state           current FSM state (0 idle, 1 run, 2 drain)
//
// Handshake: start is a level request with no ready return. It is acted on
// only on an edge where the FSM is idle; busy high means any start is ignored.
// The idle cycle that carries the done pulse already accepts a new start, so
// back-to-back tiles lose no cycles. A rejected start answers with a single
// err pulse and leaves the FSM idle.
// -----------------------------------------------------------------------------
module a_buffer_loader #(
    parameter int RAM_SIZE       = 1024,
    parameter int ADDR_WIDTH     = $clog2(RAM_SIZE),
    parameter int ARRAY_N        = 8,
    parameter int ACT_WIDTH      = 8,
    parameter int SRC_ADDR_WIDTH = 13
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [SRC_ADDR_WIDTH-1:0]   src_base_addr,
    input  logic [ADDR_WIDTH-1:0]       dst_base_addr,
    input  logic [$clog2(ARRAY_N):0]    num_rows,
    input  logic [ADDR_WIDTH:0]         row_len,
    output logic                        src_rd_en,
    output logic [SRC_ADDR_WIDTH-1:0]   src_rd_addr,
    input  logic [ACT_WIDTH-1:0]        src_rd_data,
    output logic [ADDR_WIDTH-1:0]       bram_to_ram_w_addr,
    output logic [ARRAY_N-1:0]          bram_to_ram_w_en,
    output logic [ACT_WIDTH-1:0]        bram_to_ram_w_data,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [1:0]                  dbg_state
);

    localparam int ROW_W = $clog2(ARRAY_N);
    localparam int NR_W  = ROW_W + 1;
    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int END_W = ADDR_WIDTH + 2;

    localparam logic [NR_W-1:0]  MAX_ROWS = NR_W'(ARRAY_N);
    localparam logic [END_W-1:0] RAM_END  = END_W'(RAM_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state;

    // Parameters captured on the accepting edge; inputs are ignored afterwards.
    logic [NR_W-1:0]       nr_q;
    logic [LEN_W-1:0]      len_q;
    logic [ADDR_WIDTH-1:0] dst_q;

    // Coordinates of the element being read in the current cycle.
    logic [ROW_W-1:0]      rd_r;
    logic [ADDR_WIDTH-1:0] rd_k;

    // Last value written to the A buffer, presented while no write is issued.
    logic [ACT_WIDTH-1:0]  w_data_hold;

    // ------------------------------------------------------------------
    // Start-time parameter check. The end address is computed two bits
    // wider than the RAM address so dst+len cannot alias past RAM_SIZE.
    // ------------------------------------------------------------------
    logic [END_W-1:0] end_addr;
    logic             params_illegal;

    assign end_addr = {2'b00, dst_base_addr} + {1'b0, row_len};

    always_comb begin
        params_illegal = 1'b0;
        if (num_rows == '0)        params_illegal = 1'b1;
        if (num_rows > MAX_ROWS)   params_illegal = 1'b1;
        if (row_len == '0)         params_illegal = 1'b1;
        if (end_addr > RAM_END)    params_illegal = 1'b1;
    end

    // ------------------------------------------------------------------
    // Loop-end detection for the read side: k is the inner loop, r outer.
    // ------------------------------------------------------------------
    logic last_col;
    logic last_row;

    assign last_col = ({1'b0, rd_k} == (len_q - LEN_W'(1)));
    assign last_row = ({1'b0, rd_r} == (nr_q - NR_W'(1)));

    // ------------------------------------------------------------------
    // The source BRAM returns data one cycle after the read, so the write
    // address and enable are registered alongside the read and the data is
    // taken straight from the BRAM output in the following cycle.
    // ------------------------------------------------------------------
    assign bram_to_ram_w_data = (|bram_to_ram_w_en) ? src_rd_data : w_data_hold;
    assign dbg_state          = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state              <= S_IDLE;
            nr_q               <= '0;
            len_q              <= '0;
            dst_q              <= '0;
            rd_r               <= '0;
            rd_k               <= '0;
            w_data_hold        <= '0;
            src_rd_en          <= 1'b0;
            src_rd_addr        <= '0;
            bram_to_ram_w_addr <= '0;
            bram_to_ram_w_en   <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            if (|bram_to_ram_w_en) begin
                w_data_hold <= src_rd_data;
            end

            case (state)
                S_IDLE: begin
                    bram_to_ram_w_en <= '0;
                    if (start) begin
                        if (params_illegal) begin
                            err <= 1'b1;
                        end else begin
                            nr_q        <= num_rows;
                            len_q       <= row_len;
                            dst_q       <= dst_base_addr;
                            rd_r        <= '0;
                            rd_k        <= '0;
                            src_rd_addr <= src_base_addr;
                            src_rd_en   <= 1'b1;
                            busy        <= 1'b1;
                            state       <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    // Queue the write for the element being read now.
                    bram_to_ram_w_en   <= ARRAY_N'(1) << rd_r;
                    bram_to_ram_w_addr <= dst_q + rd_k;
                    // Running source address instead of r*row_len+k.
                    src_rd_addr        <= src_rd_addr + SRC_ADDR_WIDTH'(1);
                    if (last_col) begin
                        rd_k <= '0;
                        rd_r <= rd_r + ROW_W'(1);
                        if (last_row) begin
                            src_rd_en <= 1'b0;
                            state     <= S_DRAIN;
                        end
                    end else begin
                        rd_k <= rd_k + ADDR_WIDTH'(1);
                    end
                end

                S_DRAIN: begin
                    // The final write is on the bus this cycle.
                    bram_to_ram_w_en <= '0;
                    busy             <= 1'b0;
                    done             <= 1'b1;
                    state            <= S_IDLE;
                end

                default: begin
                    bram_to_ram_w_en <= '0;
                    src_rd_en        <= 1'b0;
                    busy             <= 1'b0;
                    state            <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a_buffer_loader.sv
// -----------------------------------------------------------------------------
// tb_a_buffer_loader
//
// Directed and randomized stimulus for a_buffer_loader. The expected write
// stream of each tile is generated from the element mapping (row r, column k,
// source offset r*row_len+k) into exp_q; a monitor pops it on every write and
// checks the held address/data between writes. The main sequence checks the
// cycle timeline of each transfer (reads, busy, done, err) against the
// documented cycle numbers.
// -----------------------------------------------------------------------------
module tb_a_buffer_loader;

    localparam int RAM_SIZE       = 1024;
    localparam int ADDR_WIDTH     = 10;
    localparam int ARRAY_N        = 8;
    localparam int ACT_WIDTH      = 8;
    localparam int SRC_ADDR_WIDTH = 13;
    localparam int SRC_DEPTH      = 1 << SRC_ADDR_WIDTH;

    // ------------------------------------------------------------------
    // Clock / reset and DUT signals
    // ------------------------------------------------------------------
    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic                      start = 1'b0;
    logic [SRC_ADDR_WIDTH-1:0] src_base_addr = '0;
    logic [ADDR_WIDTH-1:0]     dst_base_addr = '0;
    logic [3:0]                num_rows = '0;
    logic [ADDR_WIDTH:0]       row_len = '0;
    logic                      src_rd_en;
    logic [SRC_ADDR_WIDTH-1:0] src_rd_addr;
    logic [ACT_WIDTH-1:0]      src_rd_data = '0;
    logic [ADDR_WIDTH-1:0]     w_addr;
    logic [ARRAY_N-1:0]        w_en;
    logic [ACT_WIDTH-1:0]      w_data;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic [1:0]                dbg_state;

    always #5 clk = ~clk;

    a_buffer_loader #(
        .RAM_SIZE       (RAM_SIZE),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .ARRAY_N        (ARRAY_N),
        .ACT_WIDTH      (ACT_WIDTH),
        .SRC_ADDR_WIDTH (SRC_ADDR_WIDTH)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .src_base_addr      (src_base_addr),
        .dst_base_addr      (dst_base_addr),
        .num_rows           (num_rows),
        .row_len            (row_len),
        .src_rd_en          (src_rd_en),
        .src_rd_addr        (src_rd_addr),
        .src_rd_data        (src_rd_data),
        .bram_to_ram_w_addr (w_addr),
        .bram_to_ram_w_en   (w_en),
        .bram_to_ram_w_data (w_data),
        .busy               (busy),
        .done               (done),
        .err                (err),
        .dbg_state          (dbg_state)
    );

    // Source BRAM model: registered read, one cycle latency.
    logic [ACT_WIDTH-1:0] mem [0:SRC_DEPTH-1];

    always @(posedge clk) begin
        if (src_rd_en) src_rd_data <= mem[src_rd_addr];
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    logic [ARRAY_N+ADDR_WIDTH+ACT_WIDTH-1:0] exp_q[$];
    bit                                      mon_en = 1'b0;
    logic [ADDR_WIDTH-1:0]                   mdl_addr = '0;
    logic [ACT_WIDTH-1:0]                    mdl_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (w_en != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {6'b0, w_en, w_addr, w_data}, 32'h0);
                end else begin
                    logic [ARRAY_N+ADDR_WIDTH+ACT_WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    chk("write_word", {6'b0, w_en, w_addr, w_data}, {6'b0, e});
                    mdl_addr = e[ACT_WIDTH +: ADDR_WIDTH];
                    mdl_data = e[ACT_WIDTH-1:0];
                end
            end else begin
                chk("w_addr_hold", {22'b0, w_addr}, {22'b0, mdl_addr});
                chk("w_data_hold", {24'b0, w_data}, {24'b0, mdl_data});
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic scramble_inputs();
        src_base_addr = SRC_ADDR_WIDTH'($urandom);
        dst_base_addr = ADDR_WIDTH'($urandom);
        num_rows      = 4'($urandom);
        row_len       = (ADDR_WIDTH+1)'($urandom);
    endtask

    // One tile transfer. Cycle 0 is the cycle whose closing edge samples
    // start. hammer keeps start high throughout (and into the done cycle);
    // launched means start was already high in the current cycle; abort_at
    // pulls reset low at the end of that cycle.
    task automatic run_xfer(input int n, input int l, input int src, input int dst,
                            input bit hammer, input bit launched, input int abort_at);
        int t;
        t = n * l;
        if (!launched) begin
            @(negedge clk);
            src_base_addr = SRC_ADDR_WIDTH'(src);
            dst_base_addr = ADDR_WIDTH'(dst);
            num_rows      = 4'(n);
            row_len       = (ADDR_WIDTH+1)'(l);
            start         = 1'b1;
        end
        for (int i = 0; i < t; i++) begin
            exp_q.push_back({ARRAY_N'(1 << (i / l)), ADDR_WIDTH'(dst + i % l),
                             mem[(src + i) % SRC_DEPTH]});
        end
        for (int c = 1; c <= t + 2; c++) begin
            @(negedge clk);
            start = hammer;
            chk("src_rd_en", {31'b0, src_rd_en}, {31'b0, (c <= t)});
            if (c <= t)
                chk("src_rd_addr", {19'b0, src_rd_addr}, 32'((src + c - 1) % SRC_DEPTH));
            if (c >= 2 && c <= t + 1)
                chk("w_en_active", {31'b0, (w_en != '0)}, 32'd1);
            else
                chk("w_en_idle", {24'b0, w_en}, 32'd0);
            chk("busy", {31'b0, busy}, {31'b0, (c <= t + 1)});
            chk("done", {31'b0, done}, {31'b0, (c == t + 2)});
            chk("err_quiet", {31'b0, err}, 32'd0);
            if (!hammer && c <= t + 1) scramble_inputs();
            if (c == abort_at) begin
                #1;
                mon_en = 1'b0;
                reset  = 1'b0;
                start  = 1'b0;
                @(negedge clk);
                chk("abort_w_en", {24'b0, w_en}, 32'd0);
                chk("abort_rd_en", {31'b0, src_rd_en}, 32'd0);
                chk("abort_busy", {31'b0, busy}, 32'd0);
                chk("abort_done", {31'b0, done}, 32'd0);
                chk("abort_w_data", {24'b0, w_data}, 32'd0);
                reset = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    chk("post_abort_done", {31'b0, done}, 32'd0);
                    chk("post_abort_w_en", {24'b0, w_en}, 32'd0);
                end
                exp_q.delete();
                mdl_addr = '0;
                mdl_data = '0;
                mon_en   = 1'b1;
                return;
            end
        end
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic illegal_start(input int n, input int l, input int dst);
        @(negedge clk);
        src_base_addr = SRC_ADDR_WIDTH'($urandom);
        dst_base_addr = ADDR_WIDTH'(dst);
        num_rows      = 4'(n);
        row_len       = (ADDR_WIDTH+1)'(l);
        start         = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ill_err", {31'b0, err}, 32'd1);
        chk("ill_busy", {31'b0, busy}, 32'd0);
        chk("ill_rd_en", {31'b0, src_rd_en}, 32'd0);
        chk("ill_w_en", {24'b0, w_en}, 32'd0);
        chk("ill_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("ill_err_pulse", {31'b0, err}, 32'd0);
        chk("ill_rd_en2", {31'b0, src_rd_en}, 32'd0);
        chk("ill_busy2", {31'b0, busy}, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < SRC_DEPTH; i++) mem[i] = ACT_WIDTH'(i);

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rd_en", {31'b0, src_rd_en}, 32'd0);
        chk("rst_rd_addr", {19'b0, src_rd_addr}, 32'd0);
        chk("rst_w_en", {24'b0, w_en}, 32'd0);
        chk("rst_w_addr", {22'b0, w_addr}, 32'd0);
        chk("rst_w_data", {24'b0, w_data}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, 32'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Full array, identity source data.
        run_xfer(8, 4, 0, 0, 1'b0, 1'b0, 0);
        // Partial rows with offsets.
        run_xfer(3, 5, 200, 100, 1'b0, 1'b0, 0);
        // Rejected launches.
        illegal_start(0, 4, 0);
        illegal_start(9, 4, 0);
        illegal_start(3, 0, 0);
        illegal_start(1, 8, 1020);
        // start held high for the whole transfer, restart on the done cycle.
        run_xfer(8, 4, 0, 0, 1'b1, 1'b0, 0);
        run_xfer(8, 4, 0, 0, 1'b0, 1'b1, 0);
        // Reset after the 10th write, then a clean rerun.
        run_xfer(8, 4, 0, 0, 1'b0, 1'b0, 11);
        run_xfer(8, 4, 0, 0, 1'b0, 1'b0, 0);
        // Source address wrap and minimum tile.
        run_xfer(1, 1, 'h1FFF, 0, 1'b0, 1'b0, 0);
        run_xfer(1, 2, 'h1FFF, 7, 1'b0, 1'b0, 0);
        // Tile ending exactly at the top of the row RAMs.
        run_xfer(2, 8, 123, 1016, 1'b0, 1'b0, 0);

        // Randomized tiles over random source contents.
        for (int i = 0; i < SRC_DEPTH; i++) mem[i] = ACT_WIDTH'($urandom);
        for (int it = 0; it < 20; it++) begin
            int n, l, d, s;
            n = int'($urandom_range(1, ARRAY_N));
            l = int'($urandom_range(1, 40));
            d = int'($urandom_range(0, RAM_SIZE - l));
            s = int'($urandom_range(0, SRC_DEPTH - 1));
            run_xfer(n, l, s, d, 1'b0, 1'b0, 0);
        end
        for (int it = 0; it < 4; it++) begin
            int l;
            l = int'($urandom_range(2, 64));
            illegal_start(int'($urandom_range(9, 15)), l, 0);
            illegal_start(int'($urandom_range(1, 8)), l, int'($urandom_range(RAM_SIZE - l + 1, RAM_SIZE - 1)));
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
